icache_ro: RTL and testbench

ICACHE_RO -- requirements
Module: icache_ro

---
 rtl/icache_pkg.sv | 18 +
 rtl/icache_array.sv | 47 ++++
 rtl/icache_ro.sv | 103 ++++++++++
 tb/tb_icache_ro.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared widths, FSM state encoding and word-select helper for the read-only instruction cache.
package icache_pkg;

  localparam int BLOCK_W    = 128;
  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 30;
  localparam int BLK_ADDR_W = ADDR_W - 2;

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t FETCH = 1'b1;

  function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                                 input logic [1:0]         off);
    word_sel = blk[WORD_W*off +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped tag/valid/data storage: one synchronous write port, asynchronous read.
module icache_array
  import icache_pkg::*;
#(
  parameter int LINES = 8,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = BLK_ADDR_W - IDX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic               we,
  input  logic [IDX_W-1:0]   wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0] wr_data
);

  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tags [LINES];
  logic [BLOCK_W-1:0] data [LINES];

  // NOTE: <= in clocked blocks so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are deliberately left out of reset; valid alone qualifies them,
  // and resetting storage would force it into flops instead of RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[rd_index];

endmodule

// File: rtl/icache_ro.sv
// Read-only direct-mapped instruction cache, 4-word blocks, blocking miss handling.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache_ro
  import icache_pkg::*;
#(
  parameter int LINES          = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  proc_ren,
  input  logic                  proc_wen,
  input  logic [ADDR_W-1:0]     proc_addr,
  input  logic [WORD_W-1:0]     proc_wdata,
  output logic [WORD_W-1:0]     proc_rdata,
  output logic                  proc_stall,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [BLK_ADDR_W-1:0] mem_addr,
  output logic [BLOCK_W-1:0]    mem_wdata,
  input  logic [BLOCK_W-1:0]    mem_rdata,
  input  logic                  mem_ready
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]           perf_hit,
  output logic [31:0]           perf_miss
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = BLK_ADDR_W - IDX_W;

  state_t                state;
  logic [BLK_ADDR_W-1:0] blk_addr;

  logic [IDX_W-1:0]   req_index;
  logic [TAG_W-1:0]   req_tag;
  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [BLOCK_W-1:0] line_data;
  logic               lookup, hit, miss, fill;

  assign req_index = proc_addr[2 +: IDX_W];
  assign req_tag   = proc_addr[ADDR_W-1 -: TAG_W];

  icache_array #(.LINES(LINES)) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (req_index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .we       (fill),
    .wr_index (blk_addr[IDX_W-1:0]),
    .wr_tag   (blk_addr[BLK_ADDR_W-1 -: TAG_W]),
    .wr_data  (mem_rdata)
  );

  // Writes are not supported, so proc_wen never starts a lookup.
  assign lookup = (state == IDLE) && proc_ren;
  assign hit    = lookup && line_valid && (line_tag == req_tag);
  assign miss   = lookup && !hit;
  assign fill   = (state == FETCH) && mem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      blk_addr <= '0;
    end else begin
      case (state)
        IDLE: if (miss) begin
          state    <= FETCH;
          blk_addr <= proc_addr[ADDR_W-1:2];
        end
        FETCH: if (mem_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign proc_stall = (state == FETCH) || miss;
  assign proc_rdata = hit ? word_sel(line_data, proc_addr[1:0]) : '0;
  assign mem_read   = (state == FETCH);
  assign mem_addr   = blk_addr;
  assign mem_write  = 1'b0;
  assign mem_wdata  = '0;

  logic unused_inputs;
  assign unused_inputs = ^{proc_wen, proc_wdata, WORDS_PER_LINE[0]};

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_hit  <= '0;
      perf_miss <= '0;
    end else begin
      if (hit && !(&perf_hit))   perf_hit  <= perf_hit + 32'd1;
      if (miss && !(&perf_miss)) perf_miss <= perf_miss + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_ro.sv
// Directed bench for icache_ro: bench-driven memory model, expected words queued then popped on service.
module tb_icache_ro;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         proc_ren, proc_wen;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata, proc_rdata;
  logic         proc_stall, mem_read, mem_write, mem_ready;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
`ifdef ICACHE_PERF_EN
  logic [31:0]  perf_hit, perf_miss;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  icache_ro #(.LINES(8), .WORDS_PER_LINE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_ren   (proc_ren),
    .proc_wen   (proc_wen),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hit   (perf_hit),
    .perf_miss  (perf_miss)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [27:0] ba, input int w);
    logic [3:0] wn;
    wn = 4'(w);
    return {ba, wn} ^ 32'hA500_0000;
  endfunction

  function automatic logic [127:0] mem_block(input logic [27:0] ba);
    return {mem_word(ba, 3), mem_word(ba, 2), mem_word(ba, 1), mem_word(ba, 0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge; expects a same-cycle hit.
  task automatic hit(input logic [29:0] addr);
    logic [31:0] exp;
    proc_ren  = 1'b1;
    proc_addr = addr;
    exp_q.push_back(mem_word(addr[29:2], int'(addr[1:0])));
    exp_hits++;
    #1;
    check($sformatf("hit_stall_%h", addr), {31'd0, proc_stall}, 32'd0);
    check($sformatf("hit_memrd_%h", addr), {31'd0, mem_read}, 32'd0);
    if (!proc_stall) begin
      exp = exp_q.pop_front();
      check($sformatf("hit_rdata_%h", addr), proc_rdata, exp);
    end
    @(negedge clk);
  endtask

  // Miss on addr; optionally switch proc_addr to new_addr in the first FETCH cycle.
  // Memory answers in the lat-th FETCH cycle, so the request stalls lat+1 cycles.
  task automatic miss(input logic [29:0] addr, input logic [29:0] new_addr, input int lat);
    proc_ren  = 1'b1;
    proc_addr = addr;
    exp_misses++;
    #1;
    check($sformatf("miss_stall0_%h", addr), {31'd0, proc_stall}, 32'd1);
    check($sformatf("miss_rdata0_%h", addr), proc_rdata, 32'd0);
    @(negedge clk);
    for (int i = 1; i <= lat; i++) begin
      if (i == 1) proc_addr = new_addr;
      if (i == lat) begin
        mem_ready = 1'b1;
        mem_rdata = mem_block(addr[29:2]);
      end
      #1;
      check($sformatf("fetch_memrd_%h_%0d", addr, i), {31'd0, mem_read}, 32'd1);
      check($sformatf("fetch_maddr_%h_%0d", addr, i), {4'd0, mem_addr}, {4'd0, addr[29:2]});
      check($sformatf("fetch_stall_%h_%0d", addr, i), {31'd0, proc_stall}, 32'd1);
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_rdata = {4{32'hDEAD_BEEF}};
  endtask

  initial begin
    rst_n = 1'b0; proc_ren = 1'b0; proc_wen = 1'b0; proc_addr = '0;
    proc_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_memrd", {31'd0, mem_read}, 32'd0);
    check("rst_stall", {31'd0, proc_stall}, 32'd0);
    check("rst_memwr", {31'd0, mem_write}, 32'd0);
    check("rst_wdata", mem_wdata[31:0] | mem_wdata[127:96], 32'd0);
    check("rst_maddr", {4'd0, mem_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss, 3-cycle memory latency, then word 0 served.
    miss(30'h10, 30'h10, 3);
    hit(30'h10);
    // Whole block resident.
    hit(30'h11); hit(30'h12); hit(30'h13);
    // Same index, different tag: evicts and re-misses.
    miss(30'h30, 30'h30, 2);
    hit(30'h33);
    miss(30'h10, 30'h10, 1);
    hit(30'h12);

    // Idle behaviour: no ren, stray mem_ready, lone write request.
    proc_ren = 1'b0; proc_wen = 1'b1; mem_ready = 1'b1;
    #1;
    check("idle_stall", {31'd0, proc_stall}, 32'd0);
    check("idle_rdata", proc_rdata, 32'd0);
    @(negedge clk);
    proc_wen = 1'b0; mem_ready = 1'b0;
    #1;
    check("idle_memrd", {31'd0, mem_read}, 32'd0);
    @(negedge clk);
    hit(30'h11);

    // Reset in the middle of a fetch.
    proc_ren = 1'b1; proc_addr = 30'h20;
    #1;
    check("rstf_stall0", {31'd0, proc_stall}, 32'd1);
    @(negedge clk);
    #1;
    check("rstf_memrd1", {31'd0, mem_read}, 32'd1);
    rst_n = 1'b0; proc_ren = 1'b0;
    @(negedge clk);
    #1;
    check("rstf_memrd0", {31'd0, mem_read}, 32'd0);
    check("rstf_stall", {31'd0, proc_stall}, 32'd0);
    exp_hits = 0; exp_misses = 0;
    rst_n = 1'b1;
    @(negedge clk);
    miss(30'h10, 30'h10, 2);
    hit(30'h10);

    // Address changes mid-fetch: 0x10 still filled, 0x44 evaluated afterwards.
    miss(30'h30, 30'h30, 1);
    miss(30'h10, 30'h44, 3);
    miss(30'h44, 30'h44, 2);
    hit(30'h44);
    hit(30'h13);

    proc_ren = 1'b0;
    #1;
    check("queue_empty", exp_q.size(), 32'd0);
`ifdef ICACHE_PERF_EN
    check("perf_hit", perf_hit, exp_hits);
    check("perf_miss", perf_miss, exp_misses);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
